// File: rtl/casilla_if.sv
`default_nettype none
// ============================================================================
//  Module      : casilla_if
//  Description : Controller <-> cell signal bundle for one memory-game cell.
//                The master (game controller) drives symbol/player/requests;
//                the slave (cell) returns its display code.
//  Revision    : 1.0  initial release
// ============================================================================
interface casilla_if;
  logic [3:0] label;
  logic       player;
  logic       select;
  logic       par;
  logic [3:0] new_state;

  modport master (output label, output player, output select, output par,
                  input  new_state);
  modport slave  (input  label, input  player, input  select, input  par,
                  output new_state);
endinterface
`default_nettype wire

// File: rtl/casilla.sv
`default_nettype none
// ============================================================================
//  Module      : casilla
//  Description : One board cell of the pairs game. Reveals its symbol when
//                selected, re-hides after HOLD_CYCLES edges unless a match is
//                reported, and becomes permanently owned by the selecting
//                player on a match.
//  Revision    : 1.0  initial release
// ============================================================================
module casilla #(
  parameter int HOLD_CYCLES = 8
) (
  input  logic      clk_Temp,
  input  logic      rst,        // asynchronous, active-low
  casilla_if.slave  bus
);

  localparam int             CW   = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CW-1:0]  LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    HIDDEN   = 2'd0,
    SHOWN    = 2'd1,
    OWNED_P0 = 2'd2,
    OWNED_P1 = 2'd3
  } state_t;

  state_t        state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [3:0]    label_q,     label_d;
  logic          player_q,    player_d;
  logic [3:0]    new_state_q, new_state_d;

  // Next-state logic: reveal on select, own on par, re-hide on timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    label_d  = label_q;
    player_d = player_q;
    case (state_q)
      HIDDEN: begin
        if (bus.select) begin
          state_d  = SHOWN;
          label_d  = bus.label;
          player_d = bus.player;
          cnt_d    = '0;
        end
      end
      SHOWN: begin
        // A match beats the timeout when both happen on the same edge.
        if (bus.par) begin
          state_d = player_q ? OWNED_P1 : OWNED_P0;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = HIDDEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        // Owned states are terminal until reset.
      end
    endcase
  end

  // Display code derived from the upcoming state so the output register
  // shows the new state on the same edge as the transition.
  always_comb begin
    new_state_d = 4'h0;
    case (state_d)
      HIDDEN:   new_state_d = 4'h0;
      SHOWN:    new_state_d = label_d;
      OWNED_P0: new_state_d = 4'hE;
      default:  new_state_d = 4'hF;
    endcase
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk_Temp or negedge rst) begin
    if (!rst) begin
      state_q     <= HIDDEN;
      cnt_q       <= '0;
      label_q     <= 4'h0;
      player_q    <= 1'b0;
      new_state_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      label_q     <= label_d;
      player_q    <= player_d;
      new_state_q <= new_state_d;
    end
  end

  assign bus.new_state = new_state_q;

endmodule
`default_nettype wire

// File: tb/tb_casilla.sv
`default_nettype none
// ============================================================================
//  Module      : tb_casilla
//  Description : Directed, table-driven bench for the casilla cell.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_casilla;

  logic clk_Temp = 1'b0;
  logic rst      = 1'b0;

  casilla_if bus  ();
  casilla_if bus1 ();

  casilla #(.HOLD_CYCLES(8)) dut (
    .clk_Temp (clk_Temp),
    .rst      (rst),
    .bus      (bus)
  );

  casilla #(.HOLD_CYCLES(1)) dut1 (
    .clk_Temp (clk_Temp),
    .rst      (rst),
    .bus      (bus1)
  );

  always #5 clk_Temp = ~clk_Temp;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       sel;
    logic       par;
    logic [3:0] label;
    logic       player;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [0:17];

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic p, input logic [3:0] l, input logic pl);
    bus.select = s;
    bus.par    = p;
    bus.label  = l;
    bus.player = pl;
  endtask

  // One rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk_Temp);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset / idle / reveal P1 / hold / match / owned immunity
    vecs[0]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0};
    vecs[1]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0};
    vecs[2]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0};
    vecs[3]  = '{1'b1, 1'b0, 4'h8, 1'b1, 4'h8};
    vecs[4]  = '{1'b0, 1'b0, 4'h2, 1'b0, 4'h8};
    vecs[5]  = '{1'b1, 1'b0, 4'h3, 1'b0, 4'h8};
    vecs[6]  = '{1'b0, 1'b0, 4'h4, 1'b1, 4'h8};
    vecs[7]  = '{1'b0, 1'b0, 4'h8, 1'b0, 4'h8};
    vecs[8]  = '{1'b0, 1'b0, 4'hC, 1'b0, 4'h8};
    vecs[9]  = '{1'b0, 1'b0, 4'h1, 1'b0, 4'h8};
    vecs[10] = '{1'b0, 1'b1, 4'h8, 1'b0, 4'hF};
    vecs[11] = '{1'b0, 1'b0, 4'h8, 1'b0, 4'hF};
    vecs[12] = '{1'b1, 1'b0, 4'h5, 1'b0, 4'hF};
    vecs[13] = '{1'b0, 1'b1, 4'h6, 1'b1, 4'hF};
    vecs[14] = '{1'b1, 1'b1, 4'h7, 1'b0, 4'hF};
    vecs[15] = '{1'b0, 1'b0, 4'h9, 1'b1, 4'hF};
    vecs[16] = '{1'b1, 1'b0, 4'hA, 1'b0, 4'hF};
    vecs[17] = '{1'b0, 1'b1, 4'hB, 1'b1, 4'hF};

    drive(1'b0, 1'b0, 4'h0, 1'b0);
    bus1.select = 1'b0;
    bus1.par    = 1'b0;
    bus1.label  = 4'h0;
    bus1.player = 1'b0;

    // Asynchronous reset before any clock edge.
    #2;
    check("reset_no_edge", bus.new_state, 4'h0);
    @(negedge clk_Temp);
    rst = 1'b1;
    #1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].sel, vecs[i].par, vecs[i].label, vecs[i].player);
      tick();
      check($sformatf("vec%0d", i), bus.new_state, vecs[i].exp);
    end

    // Mid-operation asynchronous reset from OWNED_P1, between edges.
    @(negedge clk_Temp);
    rst = 1'b0;
    #1;
    check("async_reset_owned", bus.new_state, 4'h0);
    @(negedge clk_Temp);
    rst = 1'b1;
    #1;

    // Timeout: label 5 shown for the reveal edge plus 7 more, hidden on the 8th.
    drive(1'b1, 1'b0, 4'h5, 1'b0);
    tick();
    check("reveal5", bus.new_state, 4'h5);
    drive(1'b0, 1'b0, 4'h5, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("hold5_%0d", i), bus.new_state, 4'h5);
    end
    tick();
    check("timeout_hidden", bus.new_state, 4'h0);

    // Re-selection re-latches the label.
    drive(1'b1, 1'b0, 4'h3, 1'b0);
    tick();
    check("reselect3", bus.new_state, 4'h3);

    // Counter at the last value; par and timeout coincide -> par wins.
    drive(1'b0, 1'b0, 4'h3, 1'b1);
    repeat (7) tick();
    check("pre_timeout3", bus.new_state, 4'h3);
    drive(1'b0, 1'b1, 4'h3, 1'b1);
    tick();
    check("par_beats_timeout", bus.new_state, 4'hE);
    drive(1'b1, 1'b1, 4'h9, 1'b1);
    tick();
    check("owned_p0_holds", bus.new_state, 4'hE);

    // HIDDEN ignores par; select with par reveals rather than owning.
    @(negedge clk_Temp);
    rst = 1'b0;
    #1;
    @(negedge clk_Temp);
    rst = 1'b1;
    drive(1'b0, 1'b1, 4'h9, 1'b0);
    tick();
    check("hidden_par_ignored", bus.new_state, 4'h0);
    drive(1'b1, 1'b1, 4'h9, 1'b0);
    tick();
    check("sel_and_par_reveal", bus.new_state, 4'h9);

    // Reserved label latched and displayed as-is.
    @(negedge clk_Temp);
    rst = 1'b0;
    #1;
    @(negedge clk_Temp);
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'hE, 1'b1);
    tick();
    check("reserved_label", bus.new_state, 4'hE);
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    tick();
    check("reserved_hold", bus.new_state, 4'hE);

    // HOLD_CYCLES=1: re-hides on the first edge after the reveal.
    bus1.select = 1'b1;
    bus1.label  = 4'hD;
    tick();
    check("h1_reveal", bus1.new_state, 4'hD);
    bus1.select = 1'b0;
    tick();
    check("h1_timeout", bus1.new_state, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
